// File: rtl/ntt_job_scheduler_pkg.sv
// Shared types for the NTT job scheduler: FSM state encoding and job-size helper.
package ntt_job_scheduler_pkg;

    typedef enum logic [2:0] {
        SCH_IDLE   = 3'd0,
        SCH_LOAD   = 3'd1,
        SCH_START  = 3'd2,
        SCH_RUN    = 3'd3,
        SCH_UNLOAD = 3'd4,
        SCH_DONE   = 3'd5
    } sch_state_e;

    // Words moved per job: one BRAM word feeds a full row of butterfly PEs.
    function automatic int sch_words(input int ring_depth, input int pe_depth);
        return 1 << (ring_depth - pe_depth - 1);
    endfunction

endpackage

// File: rtl/ntt_job_scheduler_if.sv
// Host/core-facing signal bundle of the NTT job scheduler; master = scheduler side.
interface ntt_job_scheduler_if #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_inv;
    logic [N_REQ-1:0]         req_ready;
    logic [$clog2(N_REQ)-1:0] owner;
    logic                     busy;
    logic                     din_valid;
    logic                     load_en;
    logic [ADDR_W-1:0]        load_addr;
    logic                     ntt_start;
    logic                     ntt_inverse;
    logic                     ntt_finished;
    logic                     dout_ready;
    logic                     unload_en;
    logic [ADDR_W-1:0]        unload_addr;
    logic                     done_valid;
    logic                     done_ready;
    logic                     done_err;

    modport master (
        input  req_valid, req_inv, din_valid, ntt_finished, dout_ready, done_ready,
        output req_ready, owner, busy, load_en, load_addr, ntt_start, ntt_inverse,
               unload_en, unload_addr, done_valid, done_err
    );

    modport slave (
        output req_valid, req_inv, din_valid, ntt_finished, dout_ready, done_ready,
        input  req_ready, owner, busy, load_en, load_addr, ntt_start, ntt_inverse,
               unload_en, unload_addr, done_valid, done_err
    );

endinterface

// File: rtl/ntt_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr (wrapping).
module ntt_job_scheduler_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    grant_idx
);

    logic [PW-1:0] j;

    // Scan from the farthest offset down so the nearest requester to ptr wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        j         = '0;
        if (en) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                j = PW'((int'(ptr) + i) % N_REQ);
                if (req[j]) begin
                    grant     = '0;
                    grant[j]  = 1'b1;
                    grant_idx = j;
                end
            end
        end
    end

endmodule

// File: rtl/ntt_job_scheduler.sv
// Shares one NTT core between N_REQ requesters: RR accept, LOAD, START, RUN, UNLOAD, DONE.
// Define NTT_SCHED_TIMEOUT_EN to add the RUN watchdog that ends a stuck job with done_err.
module ntt_job_scheduler
    import ntt_job_scheduler_pkg::*;
#(
    parameter int RING_DEPTH     = 8,
    parameter int PE_DEPTH       = 3,
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                 clk,
    input logic                 reset,
    ntt_job_scheduler_if.master bus
);

    localparam int            WORDS     = sch_words(RING_DEPTH, PE_DEPTH);
    localparam int            AW        = RING_DEPTH - PE_DEPTH - 1;
    localparam int            PW        = $clog2(N_REQ);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    if (N_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("ntt_job_scheduler: N_REQ and TIMEOUT_CYCLES must both be >= 2");
    end

    sch_state_e       state, state_nxt;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    grant_idx, ptr, ptr_nxt, owner_q;
    logic [AW-1:0]    load_cnt, unload_cnt;
    logic             accept, handshake, inv_q, err_q, timeout_hit;
    logic             load_en, unload_en, ntt_start, done_valid;

    // Arbitration only in IDLE; reset masks the combinational grant as well.
    ntt_job_scheduler_rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .req       (bus.req_valid),
        .ptr       (ptr),
        .en        (state == SCH_IDLE && !reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept    = |grant;
    assign handshake = done_valid && bus.done_ready;
    assign ptr_nxt   = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SCH_IDLE;
            ptr        <= '0;
            owner_q    <= '0;
            inv_q      <= 1'b0;
            load_cnt   <= '0;
            unload_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner_q    <= grant_idx;
                inv_q      <= |(bus.req_inv & grant);
                ptr        <= ptr_nxt;
                load_cnt   <= '0;
                unload_cnt <= '0;
            end
            if (load_en) load_cnt <= load_cnt + AW'(1);
            if (unload_en) unload_cnt <= unload_cnt + AW'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        load_en    = 1'b0;
        unload_en  = 1'b0;
        ntt_start  = 1'b0;
        done_valid = 1'b0;
        case (state)
            SCH_IDLE: begin
                if (accept) state_nxt = SCH_LOAD;
            end
            SCH_LOAD: begin
                load_en = bus.din_valid;
                if (bus.din_valid && load_cnt == LAST_ADDR) state_nxt = SCH_START;
            end
            SCH_START: begin
                ntt_start = 1'b1;
                state_nxt = SCH_RUN;
            end
            SCH_RUN: begin
                if (bus.ntt_finished) state_nxt = SCH_UNLOAD;
                else if (timeout_hit) state_nxt = SCH_DONE;
            end
            SCH_UNLOAD: begin
                unload_en = bus.dout_ready;
                if (bus.dout_ready && unload_cnt == LAST_ADDR) state_nxt = SCH_DONE;
            end
            SCH_DONE: begin
                done_valid = 1'b1;
                if (bus.done_ready) state_nxt = SCH_IDLE;
            end
            default: state_nxt = SCH_IDLE;
        endcase
    end

`ifdef NTT_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] run_cnt;

    assign timeout_hit = (state == SCH_RUN) && !bus.ntt_finished &&
                         (run_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero outside RUN, so it starts clean on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            run_cnt <= (state == SCH_RUN) ? run_cnt + TW'(1) : '0;
            if (timeout_hit) err_q <= 1'b1;
            else if (handshake) err_q <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_q       = 1'b0;
`endif

    assign bus.req_ready   = grant;
    assign bus.owner       = owner_q;
    assign bus.busy        = (state != SCH_IDLE);
    assign bus.load_en     = load_en;
    assign bus.load_addr   = load_cnt;
    assign bus.ntt_start   = ntt_start;
    assign bus.ntt_inverse = inv_q && (state != SCH_IDLE);
    assign bus.unload_en   = unload_en;
    assign bus.unload_addr = unload_cnt;
    assign bus.done_valid  = done_valid;
    assign bus.done_err    = err_q;

endmodule

// File: tb/tb_ntt_job_scheduler.sv
// Scoreboard bench for ntt_job_scheduler (RING_DEPTH=8, PE_DEPTH=3, N_REQ=2, 16 words per job).
module tb_ntt_job_scheduler;

    localparam int N_REQ    = 2;
    localparam int AW       = 4;
    localparam int WORDS    = 16;
    localparam int CORE_DLY = 40;
    localparam int TO_CYC   = 64;

    typedef struct {
        int owner;
        int inv;
        int err;
    } job_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic fin_core = 1'b0;
    logic fin_spur = 1'b0;
    bit   core_en  = 1'b1;

    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   done_cyc = 0;
    bit   prev_start = 1'b0;
    bit   prev_done = 1'b0;

    job_t job_q[$];
    int   grant_q[$];
    int   load_q[$];
    int   unload_q[$];

    always #5 clk = ~clk;

    ntt_job_scheduler_if #(.N_REQ(N_REQ), .ADDR_W(AW)) bus ();

    assign bus.ntt_finished = fin_core | fin_spur;

    ntt_job_scheduler #(
        .RING_DEPTH     (8),
        .PE_DEPTH       (3),
        .N_REQ          (N_REQ),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [N_REQ-1:0] onehot(input int r);
        return N_REQ'(1 << r);
    endfunction

    // Output monitor: pops expectations whenever the DUT produces an event.
    always @(negedge clk) begin : monitor
        int   e;
        job_t j;
        if (!reset) begin
            if (bus.busy) check("ready_while_busy", int'(bus.req_ready), 0);
            if ((bus.req_ready & bus.req_valid) != '0) begin
                e = (grant_q.size() > 0) ? int'(onehot(grant_q.pop_front())) : -1;
                check("grant", int'(bus.req_ready), e);
                acc_cyc = cyc;
            end
            if (bus.load_en) begin
                e = (load_q.size() > 0) ? load_q.pop_front() : -1;
                check("load_addr", int'(bus.load_addr), e);
            end
            if (bus.unload_en) begin
                e = (unload_q.size() > 0) ? unload_q.pop_front() : -1;
                check("unload_addr", int'(bus.unload_addr), e);
            end
            if (bus.ntt_start) begin
                check("start_pulse_width", int'(prev_start), 0);
                e = (job_q.size() > 0) ? job_q[0].inv : -1;
                check("ntt_inverse", int'(bus.ntt_inverse), e);
            end
            if (bus.done_valid && !prev_done) done_cyc = cyc;
            if (bus.done_valid && bus.done_ready) begin
                if (job_q.size() > 0) begin
                    j = job_q.pop_front();
                    check("done_owner", int'(bus.owner), j.owner);
                    check("done_err", int'(bus.done_err), j.err);
                end else begin
                    check("done_unexpected", int'(bus.done_valid), 0);
                end
            end
            prev_start = bus.ntt_start;
            prev_done  = bus.done_valid;
        end
    end

    // Core model: one finished pulse CORE_DLY cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ntt_start && core_en && !reset) begin
                repeat (CORE_DLY) @(posedge clk);
                #1 fin_core = 1'b1;
                @(posedge clk);
                #1 fin_core = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req_ready"}, int'(bus.req_ready), 0);
        check({tag, "_owner"}, int'(bus.owner), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_load_en"}, int'(bus.load_en), 0);
        check({tag, "_load_addr"}, int'(bus.load_addr), 0);
        check({tag, "_ntt_start"}, int'(bus.ntt_start), 0);
        check({tag, "_ntt_inverse"}, int'(bus.ntt_inverse), 0);
        check({tag, "_unload_en"}, int'(bus.unload_en), 0);
        check({tag, "_unload_addr"}, int'(bus.unload_addr), 0);
        check({tag, "_done_valid"}, int'(bus.done_valid), 0);
        check({tag, "_done_err"}, int'(bus.done_err), 0);
    endtask

    task automatic expect_job(input int r, input int inv, input int err, input bit with_unload);
        job_t j;
        j.owner = r;
        j.inv   = inv;
        j.err   = err;
        grant_q.push_back(r);
        job_q.push_back(j);
        for (int i = 0; i < WORDS; i++) begin
            load_q.push_back(i);
            if (with_unload) unload_q.push_back(i);
        end
    endtask

    task automatic wait_accept(input int r, input int inv, input bit drop);
        int n;
        n = 0;
        bus.req_inv   = inv != 0 ? (bus.req_inv | onehot(r)) : (bus.req_inv & ~onehot(r));
        bus.req_valid = bus.req_valid | onehot(r);
        #1;
        while ((bus.req_ready & onehot(r)) == '0 && n < 100) begin
            tick();
            n++;
        end
        check("accept_timeout", int'(n >= 100), 0);
        tick();
        if (drop) bus.req_valid = '0;
    endtask

    task automatic drive_loads(input bit toggle, input bit spurious);
        int beats;
        int c;
        beats = 0;
        c = 0;
        while (beats < WORDS && c < 200) begin
            bus.din_valid = toggle ? (c % 2 == 0) : 1'b1;
            fin_spur = spurious && (c == 3);
            if (bus.din_valid) beats++;
            c++;
            tick();
        end
        bus.din_valid = 1'b0;
        fin_spur = 1'b0;
    endtask

    task automatic drive_unload(input bit stall, input bit spurious);
        int stall_left;
        int c;
        bit spur_done;
        stall_left = stall ? 5 : 0;
        spur_done = 1'b0;
        c = 0;
        while (!bus.done_valid && c < 2000) begin
            if (stall_left > 0 && bus.unload_addr == AW'(4)) begin
                bus.dout_ready = 1'b0;
                stall_left--;
            end else begin
                bus.dout_ready = 1'b1;
            end
            fin_spur = spurious && !spur_done && bus.unload_addr == AW'(8);
            if (fin_spur) spur_done = 1'b1;
            tick();
            c++;
        end
        bus.dout_ready = 1'b0;
        fin_spur = 1'b0;
        check("done_wait_timeout", int'(c >= 2000), 0);
    endtask

    task automatic finish_done(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("done_held", int'(bus.done_valid), 1);
            tick();
        end
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        check("busy_after_done", int'(bus.busy), 0);
    endtask

    task automatic do_job(input int r, input int inv, input bit toggle, input bit stall,
                          input bit spurious, input int hold, input bit drop, input int exp_lat);
        expect_job(r, inv, 0, 1'b1);
        wait_accept(r, inv, drop);
        drive_loads(toggle, spurious);
        drive_unload(stall, spurious);
        finish_done(hold);
        if (exp_lat > 0) check("latency", done_cyc - acc_cyc, exp_lat);
        check("load_words_left", load_q.size(), 0);
        check("unload_words_left", unload_q.size(), 0);
    endtask

    initial begin : stimulus
        int n;
        bus.req_valid  = '0;
        bus.req_inv    = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        bus.done_ready = 1'b0;

        // Reset state, with requests pending to show they are masked.
        repeat (3) tick();
        bus.req_valid = 2'b11;
        #1;
        check_idle("reset");
        bus.req_valid = '0;
        reset = 1'b0;
        tick();

        // Single forward job from requester 0 with minimum latency.
        do_job(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, WORDS + 2 + CORE_DLY + WORDS);

        // Inverse job from requester 1 with din_valid toggling and a dout_ready stall.
        do_job(1, 1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 0);

        // Both requesting continuously: grants alternate, mode captured per job.
        bus.req_valid = 2'b11;
        do_job(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        do_job(1, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        do_job(0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
        do_job(1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0);

        // Spurious finished pulses in LOAD and UNLOAD; done held 10 cycles.
        do_job(0, 0, 1'b0, 1'b0, 1'b1, 10, 1'b1, WORDS + 2 + CORE_DLY + WORDS);

        // Reset in the middle of LOAD, then a fresh job must go to requester 0 from address 0.
        expect_job(0, 1, 0, 1'b1);
        wait_accept(0, 1, 1'b0);
        n = 0;
        bus.din_valid = 1'b1;
        while (bus.load_addr != AW'(7) && n < 50) begin
            tick();
            n++;
        end
        check("reach_addr7_timeout", int'(n >= 50), 0);
        reset = 1'b1;
        tick();
        check_idle("abort");
        bus.din_valid = 1'b0;
        load_q.delete();
        unload_q.delete();
        job_q.delete();
        grant_q.delete();
        reset = 1'b0;
        bus.req_valid = 2'b11;
        do_job(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, WORDS + 2 + CORE_DLY + WORDS);

        // Core never finishes.
        core_en = 1'b0;
`ifdef NTT_SCHED_TIMEOUT_EN
        expect_job(1, 0, 1, 1'b0);
        wait_accept(1, 0, 1'b1);
        drive_loads(1'b0, 1'b0);
        n = 0;
        bus.dout_ready = 1'b1;
        while (!bus.done_valid && n < 200) begin
            tick();
            n++;
        end
        bus.dout_ready = 1'b0;
        check("timeout_cycles", n, TO_CYC + 1);
        check("timeout_err_flag", int'(bus.done_err), 1);
        finish_done(0);
        check("err_cleared", int'(bus.done_err), 0);
        check("load_words_left_to", load_q.size(), 0);
`else
        expect_job(1, 0, 0, 1'b0);
        wait_accept(1, 0, 1'b1);
        drive_loads(1'b0, 1'b0);
        bus.dout_ready = 1'b1;
        repeat (10000) tick();
        check("still_busy", int'(bus.busy), 1);
        check("no_done_without_core", int'(bus.done_valid), 0);
        check("no_err_without_timeout", int'(bus.done_err), 0);
        bus.dout_ready = 1'b0;
        reset = 1'b1;
        tick();
        check_idle("stuck_reset");
        load_q.delete();
        unload_q.delete();
        job_q.delete();
        grant_q.delete();
        reset = 1'b0;
`endif
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
